// File: rtl/hello_nios2_qsys_mul_pkg.sv
// hello_nios2_qsys_mul_pkg: op encodings, FSM states and default widths for the multiply sequencer
package hello_nios2_qsys_mul_pkg;
    localparam int MUL_DATA_W = 32;
    localparam int MUL_HALF_W = MUL_DATA_W / 2;
    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULXUU = 2'b01;
    localparam logic [1:0] MUL_OP_MULXSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULXSS = 2'b11;
    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_FIX, ST_DONE} state_t;
endpackage

// File: rtl/hello_nios2_qsys_mul_pp16.sv
// hello_nios2_qsys_mul_pp16: registered unsigned half-word multiplier cell, one DSP block
module hello_nios2_qsys_mul_pp16 #(
    parameter int HALF_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [HALF_W-1:0]     i_a,
    input  logic [HALF_W-1:0]     i_b,
    output logic [2*HALF_W-1:0]   o_p
);
    always_ff @(posedge clk or posedge reset)
        if (reset) o_p <= '0;
        else       o_p <= i_a * i_b;
endmodule

// File: rtl/hello_nios2_qsys_mul_seq.sv
// hello_nios2_qsys_mul_seq: iterative 32x32 multiply sequencer, four passes through one 16x16 cell
module hello_nios2_qsys_mul_seq
    import hello_nios2_qsys_mul_pkg::*;
#(
    parameter int DATA_W = MUL_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_src1,
    input  logic [DATA_W-1:0] req_src2,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data
);
    localparam int HALF_W = DATA_W / 2;

    state_t              r_state, w_next;
    logic [2:0]          r_cnt, w_cnt_next;
    logic [1:0]          r_op;
    logic [DATA_W-1:0]   r_a, r_b, r_rsp_data;
    logic [2*DATA_W-1:0] r_acc, w_ext, w_term;
    logic [HALF_W-1:0]   w_pa, w_pb;
    logic [DATA_W-1:0]   w_pp, w_hi, w_word;
    logic                w_accept;

    assign req_ready = r_state == ST_IDLE;
    assign rsp_valid = r_state == ST_DONE;
    assign rsp_data  = r_rsp_data;
    assign w_accept  = req_valid & req_ready & ~flush;

    // cnt[0] picks the high half of A, cnt[1] the high half of B
    assign w_pa = r_cnt[0] ? r_a[DATA_W-1:HALF_W] : r_a[HALF_W-1:0];
    assign w_pb = r_cnt[1] ? r_b[DATA_W-1:HALF_W] : r_b[HALF_W-1:0];

    hello_nios2_qsys_mul_pp16 #(.HALF_W(HALF_W)) u_pp (
        .clk   (clk),
        .reset (reset),
        .i_a   (w_pa),
        .i_b   (w_pb),
        .o_p   (w_pp)
    );

    // Cell output lags the issue by one cycle, so cnt names the term issued at cnt-1
    assign w_ext  = {{DATA_W{1'b0}}, w_pp};
    assign w_term = (r_cnt == 3'd4) ? w_ext << DATA_W :
                    (r_cnt == 3'd1) ? w_ext : w_ext << HALF_W;

    // Signed high words come from the unsigned product minus the sign-weighted cross operands
    assign w_hi = r_acc[2*DATA_W-1:DATA_W]
                - ((r_op[1] & r_a[DATA_W-1]) ? r_b : '0)
                - ((r_op == MUL_OP_MULXSS && r_b[DATA_W-1]) ? r_a : '0);
    assign w_word = (r_op == MUL_OP_MUL) ? r_acc[DATA_W-1:0] : w_hi;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            ST_IDLE: if (w_accept) begin
                w_next     = ST_MUL;
                w_cnt_next = '0;
            end
            ST_MUL: begin
                w_cnt_next = r_cnt + 3'd1;
                if (r_cnt == 3'd4) w_next = ST_FIX;
            end
            ST_FIX:  w_next = ST_DONE;
            ST_DONE: if (rsp_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
        if (flush) begin
            w_next     = ST_IDLE;
            w_cnt_next = '0;
        end
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_rsp_data <= '0;
        end else begin
            if (w_accept) begin
                r_op  <= req_op;
                r_a   <= req_src1;
                r_b   <= req_src2;
                r_acc <= '0;
            end else if (r_state == ST_MUL && r_cnt != 3'd0) begin
                r_acc <= r_acc + w_term;
            end
            if (r_state == ST_FIX && !flush) r_rsp_data <= w_word;
        end
endmodule

// File: tb/tb_hello_nios2_qsys_mul_seq.sv
// tb_hello_nios2_qsys_mul_seq: directed vector table plus backpressure, flush and reset sequences
module tb_hello_nios2_qsys_mul_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_src1 = '0;
    logic [31:0] req_src2 = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    hello_nios2_qsys_mul_seq dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_src1  (req_src1),
        .req_src2  (req_src2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        chk("req_ready_before_accept", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_src1  = a;
        req_src2  = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_src1  = $urandom;
        req_src2  = $urandom;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic watch_idle(input string nm, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen++;
        end
        chk(nm, seen, 0);
    endtask

    initial begin
        int lat;
        vecs[0] = '{2'b00, 32'h00012345, 32'h00000010, 32'h00123450};
        vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[2] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
        vecs[3] = '{2'b11, 32'h80000000, 32'h80000000, 32'h40000000};
        vecs[4] = '{2'b11, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF};
        vecs[5] = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[6] = '{2'b10, 32'h00000002, 32'h80000000, 32'h00000001};
        vecs[7] = '{2'b00, 32'h00010001, 32'h00010001, 32'h00020001};
        vecs[8] = '{2'b01, 32'h00010001, 32'h00010001, 32'h00000001};
        vecs[9] = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};

        repeat (2) @(negedge clk);
        chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_rsp(lat);
            chk($sformatf("latency_v%0d", i), lat, 6);
            chk($sformatf("data_v%0d", i), rsp_data, vecs[i].exp);
            @(posedge clk);
            #1;
            chk($sformatf("release_v%0d", i), {30'b0, req_ready, rsp_valid}, 32'd2);
        end

        rsp_ready = 1'b0;
        start_op(2'b11, 32'h80000000, 32'h80000000);
        wait_rsp(lat);
        chk("bp_latency", lat, 6);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_data", rsp_data, 32'h40000000);
            chk("bp_hold_flags", {30'b0, req_ready, rsp_valid}, 32'd1);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release", {30'b0, req_ready, rsp_valid}, 32'd2);

        @(negedge clk);
        req_valid = 1'b1;
        flush     = 1'b1;
        req_op    = 2'b01;
        req_src1  = 32'h3;
        req_src2  = 32'h5;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        chk("idle_flush_no_accept", {31'b0, req_ready}, 32'd1);
        watch_idle("idle_flush_no_rsp", 8);

        start_op(2'b01, 32'h12345678, 32'h9ABCDEF0);
        repeat (2) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_to_idle", {31'b0, req_ready}, 32'd1);
        watch_idle("flush_no_rsp", 10);

        start_op(2'b01, 32'h12345678, 32'h9ABCDEF0);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("reset_fix_flags", {30'b0, req_ready, rsp_valid}, 32'd2);
        chk("reset_fix_data", rsp_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        watch_idle("reset_no_rsp", 10);

        start_op(2'b01, 32'h00010000, 32'h00010000);
        wait_rsp(lat);
        chk("post_abort_latency", lat, 6);
        chk("post_abort_data", rsp_data, 32'h00000001);
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
